// File: rtl/vector_checker_if.sv
// Control, result and vector-RAM write port bundle for vector_checker.
// The tester side uses the master modport and the checker uses the slave modport.
interface vector_checker_if #(
  parameter int unsigned NUM_PINS = 14,
  parameter int unsigned NUM_VEC  = 16
);
  localparam int unsigned VW = $clog2(NUM_VEC);

  logic                Run;
  logic                Done;
  logic                RSLT;
  logic                busy;
  logic [NUM_PINS-1:0] dir_mask;
  logic [NUM_PINS-1:0] care_mask;
  logic                vec_wr_en;
  logic [VW-1:0]       vec_wr_addr;
  logic [NUM_PINS-1:0] vec_wr_drive;
  logic [NUM_PINS-1:0] vec_wr_expect;
  logic [VW:0]         vec_count;
  logic [VW-1:0]       fail_idx;
  logic [NUM_PINS-1:0] fail_mask;

  modport master (
    output Run, dir_mask, care_mask, vec_wr_en, vec_wr_addr, vec_wr_drive, vec_wr_expect,
           vec_count,
    input  Done, RSLT, busy, fail_idx, fail_mask
  );

  modport slave (
    input  Run, dir_mask, care_mask, vec_wr_en, vec_wr_addr, vec_wr_drive, vec_wr_expect,
           vec_count,
    output Done, RSLT, busy, fail_idx, fail_mask
  );
endinterface

// File: rtl/vector_checker.sv
// Pin-level test-vector checker: applies stored drive patterns, waits, compares synchronised pins.
// Define CHK_STOP_ON_FAIL_EN to end a run at the first failing vector.
module vector_checker #(
  parameter int unsigned NUM_PINS      = 14,
  parameter int unsigned NUM_VEC       = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  vector_checker_if.slave     bus,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oe
);
  localparam int unsigned VW = $clog2(NUM_VEC);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam logic [VW:0]   NumVecL    = (VW + 1)'(NUM_VEC);
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [NUM_PINS-1:0] r_drive_mem  [NUM_VEC];
  logic [NUM_PINS-1:0] r_expect_mem [NUM_VEC];
  logic [NUM_PINS-1:0] r_sync1;
  logic [NUM_PINS-1:0] r_sync2;
  logic [NUM_PINS-1:0] r_dir;
  logic [NUM_PINS-1:0] r_care;
  logic [VW:0]         r_count;
  logic [VW-1:0]       r_k;
  logic [CW-1:0]       r_cnt;
  logic                r_rslt;
  logic [VW-1:0]       r_fail_idx;
  logic [NUM_PINS-1:0] r_fail_mask;

  logic [VW:0]         w_cnt_sat;
  logic [NUM_PINS-1:0] w_mism;
  logic                w_last;
  logic                w_busy;

  assign w_cnt_sat = (bus.vec_count > NumVecL) ? NumVecL : bus.vec_count;
  assign w_mism    = (r_sync2 ^ r_expect_mem[r_k]) & r_care & ~r_dir;
  assign w_last    = ({1'b0, r_k} == (r_count - 1'b1));
  assign w_busy    = (r_state == StApply) || (r_state == StSettle) || (r_state == StCheck);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.Run) begin
          w_state_next = (w_cnt_sat == '0) ? StDone : StApply;
        end
      end
      StApply:  w_state_next = StSettle;
      StSettle: begin
        if (r_cnt == SettleLast) begin
          w_state_next = StCheck;
        end
      end
      StCheck: begin
`ifdef CHK_STOP_ON_FAIL_EN
        if (w_last || (w_mism != '0)) begin
`else
        if (w_last) begin
`endif
          w_state_next = StDone;
        end else begin
          w_state_next = StApply;
        end
      end
      StDone: begin
        // Leaving DONE only on Run low keeps a held Run from restarting the check.
        if (!bus.Run) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_dir       <= '0;
      r_care      <= '0;
      r_count     <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_rslt      <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_mask <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.Run) begin
            r_dir       <= bus.dir_mask;
            r_care      <= bus.care_mask;
            r_count     <= w_cnt_sat;
            r_k         <= '0;
            r_rslt      <= 1'b1;
            r_fail_idx  <= '0;
            r_fail_mask <= '0;
          end
        end
        StApply:  r_cnt <= '0;
        StSettle: r_cnt <= r_cnt + 1'b1;
        StCheck: begin
          if (w_mism != '0) begin
            r_fail_mask <= r_fail_mask | w_mism;
            if (r_rslt) begin
              r_fail_idx <= r_k;
              r_rslt     <= 1'b0;
            end
          end
          if (w_state_next == StApply) begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Vector RAM is deliberately not reset so a mid-run abort keeps the loaded program.
  always_ff @(posedge Clk) begin
    if (!Reset && bus.vec_wr_en && !w_busy && ({1'b0, bus.vec_wr_addr} < NumVecL)) begin
      r_drive_mem[bus.vec_wr_addr]  <= bus.vec_wr_drive;
      r_expect_mem[bus.vec_wr_addr] <= bus.vec_wr_expect;
    end
  end

  assign pin_oe        = w_busy ? r_dir : '0;
  assign pin_out       = w_busy ? (r_drive_mem[r_k] & r_dir) : '0;
  assign bus.Done      = (r_state == StDone);
  assign bus.busy      = w_busy;
  assign bus.RSLT      = r_rslt;
  assign bus.fail_idx  = r_fail_idx;
  assign bus.fail_mask = r_fail_mask;
endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: a NAND-gate device model on pins 1-3 plus a run-level
// reference model checked every cycle, with literal expectations for each scenario.
module tb_vector_checker;
  localparam int NP = 14;
  localparam int NV = 16;
  localparam int S  = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NP-1:0] pin_in;
  logic [NP-1:0] pin_out;
  logic [NP-1:0] pin_oe;
  int            env_mode = 0;  // 0 good NAND, 1 pin3 stuck-at-1, 2 pin3 stuck-at-0

  int n_checks = 0;
  int n_fail   = 0;

  vector_checker_if #(.NUM_PINS(NP), .NUM_VEC(NV)) bus ();

  vector_checker #(.NUM_PINS(NP), .NUM_VEC(NV), .SETTLE_CYCLES(S)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus    (bus),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .pin_oe (pin_oe)
  );

  always #5 Clk = ~Clk;

  // Device under test on the tester: pin3 is a NAND of pins 1 and 2, other pins loop back.
  function automatic logic [NP-1:0] env_resp(logic [NP-1:0] po, logic [NP-1:0] oe, int mode);
    logic [NP-1:0] r;
    r = po & oe;
    if (mode == 1)      r[2] = 1'b1;
    else if (mode == 2) r[2] = 1'b0;
    else                r[2] = ~(r[0] & r[1]);
    return r;
  endfunction

  assign pin_in = env_resp(pin_out, pin_oe, env_mode);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bench copy of the vector RAM plus expected run outcome.
  logic [NP-1:0] m_drv [NV];
  logic [NP-1:0] m_exp [NV];
  logic [NP-1:0] m_dir;
  bit            m_armed = 1'b0;
  int            m_t;
  int            m_len;
  logic          m_rslt;
  int            m_idx;
  logic [NP-1:0] m_mask;

  task automatic model_start(int cnt, int mode);
    int            n;
    logic [NP-1:0] resp;
    logic [NP-1:0] mism;
    n      = (cnt > NV) ? NV : cnt;
    m_dir  = bus.dir_mask;
    m_rslt = 1'b1;
    m_idx  = 0;
    m_mask = '0;
    for (int k = 0; k < n; k++) begin
      resp = env_resp(m_drv[k] & m_dir, m_dir, mode);
      mism = (resp ^ m_exp[k]) & bus.care_mask & ~m_dir;
      if (mism != '0) begin
        if (m_rslt) begin
          m_idx  = k;
          m_rslt = 1'b0;
        end
        m_mask |= mism;
`ifdef CHK_STOP_ON_FAIL_EN
        n = k + 1;
        break;
`endif
      end
    end
    m_len   = n * (S + 2);
    m_t     = -1;
    m_armed = 1'b1;
  endtask

  // m_t counts edges after the one that samples Run; each vector owns S+2 of them.
  always @(negedge Clk) begin
    if (m_armed) begin
      if (m_t >= 0) begin
        if (m_t < m_len) begin
          chk("busy_run", bus.busy, 1);
          chk("done_run", bus.Done, 0);
          chk("oe_run", pin_oe, m_dir);
          chk("out_run", pin_out, m_drv[m_t / (S + 2)] & m_dir);
        end else begin
          chk("busy_done", bus.busy, 0);
          chk("done_done", bus.Done, 1);
          chk("oe_done", pin_oe, 0);
          chk("out_done", pin_out, 0);
          chk("rslt_model", bus.RSLT, m_rslt);
          chk("fidx_model", bus.fail_idx, m_idx);
          chk("fmask_model", bus.fail_mask, m_mask);
        end
      end
      m_t++;
    end
  end

  task automatic write_vec(int addr, logic [NP-1:0] drv, logic [NP-1:0] exp);
    @(posedge Clk); #1;
    bus.vec_wr_en     = 1'b1;
    bus.vec_wr_addr   = addr[3:0];
    bus.vec_wr_drive  = drv;
    bus.vec_wr_expect = exp;
    m_drv[addr]       = drv;
    m_exp[addr]       = exp;
    @(posedge Clk); #1;
    bus.vec_wr_en = 1'b0;
  endtask

  function automatic logic [NP-1:0] good_exp(int k);
    logic [NP-1:0] e;
    e    = 14'h2A00;
    e[2] = ~(k[0] & k[1]);
    return e;
  endfunction

  // Runs one check; cycles counts edges from the Run-sampling edge to Done visible.
  task automatic do_run(int cnt, int mode, int hold, bit inject, output int cycles);
    @(posedge Clk); #1;
    bus.vec_count = cnt[4:0];
    env_mode      = mode;
    model_start(cnt, mode);
    bus.Run = 1'b1;
    cycles  = 0;
    while (1) begin
      @(posedge Clk);
      cycles++;
      #1;
      bus.vec_wr_en = 1'b0;
      if (bus.Done) break;
      if (cycles >= 300) begin
        chk("done_timeout", 0, 1);
        break;
      end
      if (inject && cycles == 5) begin
        bus.vec_wr_en     = 1'b1;
        bus.vec_wr_addr   = 4'd0;
        bus.vec_wr_drive  = 14'h0000;
        bus.vec_wr_expect = 14'h0000;
      end
    end
    repeat (hold) begin
      @(posedge Clk); #1;
    end
    bus.Run = 1'b0;
    @(posedge Clk); #1;
    m_armed = 1'b0;
    chk("done_drop", bus.Done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int cyc;
    int seen;
    Reset             = 1'b1;
    bus.Run           = 1'b0;
    bus.dir_mask      = 14'h0003;
    bus.care_mask     = 14'h0004;
    bus.vec_wr_en     = 1'b0;
    bus.vec_wr_addr   = '0;
    bus.vec_wr_drive  = '0;
    bus.vec_wr_expect = '0;
    bus.vec_count     = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_done", bus.Done, 0);
    chk("rst_rslt", bus.RSLT, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_oe", pin_oe, 0);
    chk("rst_out", pin_out, 0);
    chk("rst_fidx", bus.fail_idx, 0);
    chk("rst_fmask", bus.fail_mask, 0);
    Reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      write_vec(k, 14'h3F00 | 14'(k % 4), good_exp(k % 4));
    end

    do_run(4, 0, 0, 1'b0, cyc);
    chk("nand_cycles", cyc, 25);
    chk("nand_rslt", bus.RSLT, 1);
    chk("nand_fmask", bus.fail_mask, 0);

    do_run(4, 1, 0, 1'b0, cyc);
    chk("sa1_cycles", cyc, 25);
    chk("sa1_rslt", bus.RSLT, 0);
    chk("sa1_fidx", bus.fail_idx, 3);
    chk("sa1_fmask", bus.fail_mask, 14'h0004);

    do_run(4, 2, 0, 1'b0, cyc);
`ifdef CHK_STOP_ON_FAIL_EN
    chk("sa0_cycles", cyc, 7);
`else
    chk("sa0_cycles", cyc, 25);
`endif
    chk("sa0_rslt", bus.RSLT, 0);
    chk("sa0_fidx", bus.fail_idx, 0);
    chk("sa0_fmask", bus.fail_mask, 14'h0004);

    do_run(0, 0, 0, 1'b0, cyc);
    chk("cnt0_cycles", cyc, 1);
    chk("cnt0_rslt", bus.RSLT, 1);

    // A bad last vector proves all 16 run when 31 are requested.
    write_vec(15, 14'h3F03, good_exp(3) ^ 14'h0004);
    do_run(31, 0, 0, 1'b0, cyc);
    chk("cnt31_cycles", cyc, 97);
    chk("cnt31_rslt", bus.RSLT, 0);
    chk("cnt31_fidx", bus.fail_idx, 15);
    write_vec(15, 14'h3F03, good_exp(3));

    do_run(4, 0, 5, 1'b1, cyc);
    chk("busywr_rslt", bus.RSLT, 1);
    do_run(4, 0, 0, 1'b0, cyc);
    chk("rerun_cycles", cyc, 25);
    chk("rerun_rslt", bus.RSLT, 1);

    // Reset during SETTLE of vector 2, colliding with a Run and a RAM write.
    @(posedge Clk); #1;
    bus.vec_count = 5'd4;
    env_mode      = 0;
    model_start(4, 0);
    bus.Run = 1'b1;
    cyc     = 0;
    while (cyc < 15) begin
      @(posedge Clk);
      cyc++;
      #1;
    end
    m_armed           = 1'b0;
    Reset             = 1'b1;
    bus.vec_wr_en     = 1'b1;
    bus.vec_wr_addr   = 4'd1;
    bus.vec_wr_drive  = 14'h0000;
    bus.vec_wr_expect = 14'h0000;
    @(posedge Clk); #1;
    chk("abort_oe", pin_oe, 0);
    chk("abort_out", pin_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.Done, 0);
    chk("abort_rslt", bus.RSLT, 0);
    chk("abort_fmask", bus.fail_mask, 0);
    Reset         = 1'b0;
    bus.Run       = 1'b0;
    bus.vec_wr_en = 1'b0;
    seen          = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (bus.Done || bus.busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    do_run(4, 0, 0, 1'b0, cyc);
    chk("ram_kept_cycles", cyc, 25);
    chk("ram_kept_rslt", bus.RSLT, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 SHALL have parameter NUM_PINS, default 14: DUT package pin count; bit p maps to Pin(p+1).
REQ-002 SHALL have parameter NUM_VEC, default 16: test-vector RAM depth; VW = clog2(NUM_VEC).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4: drive-to-sample delay; legal minimum 3.
REQ-004 Ports, clock and reset first: Clk in 1 (the one clock); Reset in 1 (synchronous, active-high).
REQ-005 Run in 1: start request; Done out 1: check complete; RSLT out 1: 1 = pass.
REQ-006 dir_mask in NUM_PINS (1 = checker drives the pin); care_mask in NUM_PINS (1 = compare the pin).
REQ-007 vec_wr_en in 1; vec_wr_addr in VW; vec_wr_drive in NUM_PINS; vec_wr_expect in NUM_PINS: vector RAM write port.
REQ-008 vec_count in VW+1: number of vectors to run.
REQ-009 pin_in in NUM_PINS (raw, asynchronous); pin_out out NUM_PINS; pin_oe out NUM_PINS (tristate enables for the top level).
REQ-010 busy out 1; fail_idx out VW: first failing vector; fail_mask out NUM_PINS: mismatching pins.

Function
REQ-011 pin_in SHALL pass through a 2-flop synchroniser before any comparison.
REQ-012 FSM states SHALL be IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-013 IDLE: when Run=1 at a clock edge, latch dir_mask, care_mask, and min(vec_count, NUM_VEC); clear results; set vector index k=0; go to APPLY.
REQ-014 If the latched count is 0, IDLE SHALL go directly to DONE with RSLT=1.
REQ-015 APPLY (1 cycle): drive pin_out = drive[k]; go to SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK; pin_out is held throughout.
REQ-017 CHECK (1 cycle): mism = (sync_pin_in XOR expect[k]) AND care AND NOT dir.
REQ-018 On nonzero mism with no prior failure: set fail_idx=k and RSLT=0; fail_mask |= mism.
REQ-019 After CHECK: if k = count-1, go to DONE; otherwise k++ and go to APPLY.
REQ-020 Cycles per vector SHALL be SETTLE_CYCLES+2; a full run without early stop takes count*(SETTLE_CYCLES+2)+1 cycles from Run to Done.
REQ-021 pin_oe SHALL equal latched dir_mask in APPLY/SETTLE/CHECK, and 0 in IDLE/DONE.
REQ-022 pin_out SHALL be 0 whenever pin_oe=0.
REQ-023 DONE: Done=1; stay while Run=1; go to IDLE on Run=0. RSLT, fail_idx and fail_mask SHALL hold until the next start.
REQ-024 busy SHALL be 1 in APPLY, SETTLE and CHECK.
REQ-025 Vector RAM writes SHALL take effect when busy=0 and be ignored when busy=1.
REQ-026 A write to vec_wr_addr >= NUM_VEC SHALL be ignored.
REQ-027 Run held high out of IDLE SHALL not retrigger until Run has been seen low in DONE.

Reset
REQ-028 Reset SHALL force, at the next edge: IDLE, Done=0, RSLT=0, busy=0, pin_oe=0, pin_out=0, fail_idx=0, fail_mask=0, k=0.
REQ-029 Reset mid-run SHALL abort the run with no Done pulse; vector RAM contents SHALL be preserved.
REQ-030 Reset SHALL take priority over a simultaneous Run or write.

Configuration
REQ-031 With CHK_STOP_ON_FAIL_EN defined, CHECK with nonzero mism SHALL go directly to DONE.
REQ-032 Without CHK_STOP_ON_FAIL_EN, all count vectors SHALL run; fail_mask accumulates across all vectors and fail_idx keeps the first failure.

Verification
REQ-033 NAND-gate pass: load 4 vectors with pin3 expect = NAND(pin1,pin2); dir_mask=0x0003; care=0x0004; DUT model correct; count=4 -> Done after 4*6+1=25 cycles, RSLT=1, fail_mask=0.
REQ-034 Stuck-at fault, macro off: same vectors, model pin3 stuck 1 -> RSLT=0, fail_idx=3 (vector 1,1), fail_mask=0x0004.
REQ-035 Stuck-at fault, macro on: pin3 stuck 0 -> Done right after vector 0's CHECK, fail_idx=0, total 7 cycles.
REQ-036 Count boundaries: vec_count=0 -> Done the cycle after Run, RSLT=1; vec_count=31 with NUM_VEC=16 -> exactly 16 vectors run.
REQ-037 Reset mid-SETTLE of vector 2 -> pin_oe=0 at the next edge, Done stays 0, RAM readback unchanged.
REQ-038 Handshake: write attempted while busy is ignored; Run held high -> Done held; Run low -> IDLE; second Run reruns the check.
